// File: rtl/systolic_feeder_pkg.sv
// Shared array geometry, feeder timing constants and the feeder state encoding.
package systolic_feeder_pkg;
    localparam int ARRAY_ROWS   = 8;
    localparam int ARRAY_COLS   = 8;
    localparam int ACT_WIDTH    = 8;
    localparam int WGT_WIDTH    = 8;
    localparam int MAC_LATENCY  = 3;
    localparam int K_WIDTH      = 16;
    // Enabled cycles needed for the last beat to reach the far corner PE and retire.
    localparam int FLUSH_CYCLES = (ARRAY_ROWS - 1) + (ARRAY_COLS - 1) + MAC_LATENCY;
    localparam int FLUSH_W      = $clog2(FLUSH_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } feeder_state_t;
endpackage

// File: rtl/systolic_feeder_if.sv
// Joint activation/weight stream from the tile buffers into the feeder.
interface systolic_feeder_if;
    import systolic_feeder_pkg::*;

    logic                            act_valid;
    logic                            act_ready;
    logic [ACT_WIDTH*ARRAY_ROWS-1:0] act_data;
    logic                            wgt_valid;
    logic                            wgt_ready;
    logic [WGT_WIDTH*ARRAY_COLS-1:0] wgt_data;

    modport master (
        output act_valid, act_data, wgt_valid, wgt_data,
        input  act_ready, wgt_ready
    );

    modport slave (
        input  act_valid, act_data, wgt_valid, wgt_data,
        output act_ready, wgt_ready
    );
endinterface

// File: rtl/systolic_feeder_act_skew_line.sv
// Enable-gated delay line that skews one activation row by DEPTH array cycles.
module act_skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else if (en) begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign dout = stages[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// West/north boundary feeder for the 8x8 weight-stationary array: skews
// activations, sequences array controls and zero-flushes the pipeline per tile.
//
//   state | meaning
//   IDLE  | waiting for start
//   CLEAR | one cycle clearing array accumulators and feeder skew lines
//   FEED  | accepting joint act/wgt beats; no beat means array stalled
//   DRAIN | FLUSH_CYCLES enabled cycles pushing zeros through the array
//   DONE  | one-cycle completion pulse; accumulators hold the tile result
module systolic_feeder
    import systolic_feeder_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [K_WIDTH-1:0]              k_len,
    output logic                            busy,
    output logic                            done,
    output logic                            tile_overflow,
    systolic_feeder_if.slave                strm,
    output logic                            sa_enable,
    output logic                            sa_clear_acc,
    output logic                            sa_valid_reset,
    output logic [ACT_WIDTH*ARRAY_ROWS-1:0] sa_act_packed,
    output logic [WGT_WIDTH*ARRAY_COLS-1:0] sa_wgt_packed,
    output logic                            sa_data_valid_in,
    input  logic                            sa_any_overflow
);
    feeder_state_t      state;
    logic [K_WIDTH-1:0] beats_left;
    logic [FLUSH_W-1:0] flush_cnt;
    logic               fire;
    logic               skew_clr;

    assign fire          = (state == FEED) && strm.act_valid && strm.wgt_valid;
    assign strm.act_ready = (state == FEED) && strm.wgt_valid;
    assign strm.wgt_ready = (state == FEED) && strm.act_valid;

    assign busy             = (state != IDLE);
    assign done             = (state == DONE);
    assign sa_clear_acc     = (state == CLEAR);
    assign sa_valid_reset   = (state == CLEAR);
    assign sa_enable        = fire || (state == DRAIN);
    assign sa_data_valid_in = fire;
    assign sa_wgt_packed    = fire ? strm.wgt_data : '0;
    assign skew_clr         = rst || (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beats_left    <= '0;
            flush_cnt     <= '0;
            tile_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tile_overflow <= 1'b0;
                        beats_left    <= k_len;
                        state         <= (k_len == '0) ? DONE : CLEAR;
                    end
                end
                CLEAR: begin
                    tile_overflow <= 1'b0;
                    state         <= FEED;
                end
                FEED: begin
                    if (fire) begin
                        tile_overflow <= tile_overflow | sa_any_overflow;
                        beats_left    <= beats_left - K_WIDTH'(1);
                        if (beats_left == K_WIDTH'(1)) begin
                            flush_cnt <= FLUSH_W'(FLUSH_CYCLES - 1);
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    tile_overflow <= tile_overflow | sa_any_overflow;
                    if (flush_cnt == '0) state <= DONE;
                    else                 flush_cnt <= flush_cnt - FLUSH_W'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Row 0 needs no delay; deeper rows see zeros whenever no beat is accepted.
    assign sa_act_packed[0 +: ACT_WIDTH] = fire ? strm.act_data[0 +: ACT_WIDTH] : '0;

    for (genvar r = 1; r < ARRAY_ROWS; r++) begin : g_skew
        act_skew_line #(
            .DEPTH(r),
            .WIDTH(ACT_WIDTH)
        ) u_skew (
            .clk  (clk),
            .clr  (skew_clr),
            .en   (sa_enable),
            .din  (fire ? strm.act_data[r*ACT_WIDTH +: ACT_WIDTH] : '0),
            .dout (sa_act_packed[r*ACT_WIDTH +: ACT_WIDTH])
        );
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: tile latency, skew, stalls, overflow, reset and back-to-back starts.
module tb_systolic_feeder;
    import systolic_feeder_pkg::*;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            start;
    logic [K_WIDTH-1:0]              k_len;
    logic                            busy, done, tile_overflow;
    logic                            sa_enable, sa_clear_acc, sa_valid_reset;
    logic                            sa_data_valid_in, sa_any_overflow;
    logic [ACT_WIDTH*ARRAY_ROWS-1:0] sa_act_packed;
    logic [WGT_WIDTH*ARRAY_COLS-1:0] sa_wgt_packed;
    logic [ACT_WIDTH*ARRAY_ROWS-1:0] act_pat;
    logic [WGT_WIDTH*ARRAY_COLS-1:0] wgt_pat;

    systolic_feeder_if fif();

    systolic_feeder dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .k_len            (k_len),
        .busy             (busy),
        .done             (done),
        .tile_overflow    (tile_overflow),
        .strm             (fif.slave),
        .sa_enable        (sa_enable),
        .sa_clear_acc     (sa_clear_acc),
        .sa_valid_reset   (sa_valid_reset),
        .sa_act_packed    (sa_act_packed),
        .sa_wgt_packed    (sa_wgt_packed),
        .sa_data_valid_in (sa_data_valid_in),
        .sa_any_overflow  (sa_any_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int lat, dv_cnt, en_cnt, clr_cnt, row3_first, ovf_at_done, wgt_tot0, col_sum;
    int row_tot [ARRAY_ROWS];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"}, tile_overflow, 0);
        chk({tag, "_act_ready"}, fif.act_ready, 0);
        chk({tag, "_wgt_ready"}, fif.wgt_ready, 0);
        chk({tag, "_enable"}, sa_enable, 0);
        chk({tag, "_clear"}, sa_clear_acc, 0);
        chk({tag, "_vreset"}, sa_valid_reset, 0);
        chk({tag, "_dv"}, sa_data_valid_in, 0);
        chk({tag, "_act"}, sa_act_packed, 0);
        chk({tag, "_wgt"}, sa_wgt_packed, 0);
    endtask

    // Called in an IDLE cycle; returns after stepping out of DONE into IDLE.
    task automatic run_tile(input int k, input int stall_at, input int stall_len,
                            input int ovf_at, input int start_at);
        int  c;
        bit  seen3;
        lat = -1; dv_cnt = 0; en_cnt = 0; clr_cnt = 0; row3_first = -1;
        ovf_at_done = -1; wgt_tot0 = 0; seen3 = 0;
        for (int r = 0; r < ARRAY_ROWS; r++) row_tot[r] = 0;
        k_len         = K_WIDTH'(k);
        start         = 1'b1;
        fif.act_valid = 1'b1;
        fif.wgt_valid = 1'b1;
        fif.act_data  = act_pat;
        fif.wgt_data  = wgt_pat;
        tick();
        start = 1'b0;
        c = 1;
        while (c < 200) begin
            fif.wgt_valid   = !(c >= stall_at && c < stall_at + stall_len);
            sa_any_overflow = (c == ovf_at);
            start           = (c == start_at);
            #1;
            if (c >= stall_at && c < stall_at + stall_len) begin
                chk("stall_enable", sa_enable, 0);
                chk("stall_act_ready", fif.act_ready, 0);
            end
            if (c == 1 && k != 0) begin
                chk("clear_cycle_clear_acc", sa_clear_acc, 1);
                chk("clear_cycle_act_ready", fif.act_ready, 0);
            end
            if (c == 2 && k != 0) chk("ovf_cleared_after_clear", tile_overflow, 0);
            if (sa_data_valid_in) dv_cnt++;
            if (sa_clear_acc) clr_cnt++;
            if (!seen3 && sa_act_packed[3*ACT_WIDTH +: ACT_WIDTH] != '0) begin
                seen3 = 1;
                row3_first = en_cnt;
            end
            if (sa_enable) begin
                en_cnt++;
                for (int r = 0; r < ARRAY_ROWS; r++)
                    row_tot[r] += int'(sa_act_packed[r*ACT_WIDTH +: ACT_WIDTH]);
                wgt_tot0 += int'(sa_wgt_packed[0 +: WGT_WIDTH]);
            end
            if (done) begin
                lat = c;
                ovf_at_done = int'(tile_overflow);
                break;
            end
            tick();
            c++;
        end
        start = 1'b0;
        sa_any_overflow = 1'b0;
        if (lat < 0) chk("tile_timeout_done", done, 1);
        col_sum = 0;
        for (int r = 0; r < ARRAY_ROWS; r++) col_sum += row_tot[r];
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        for (int r = 0; r < ARRAY_ROWS; r++) act_pat[r*ACT_WIDTH +: ACT_WIDTH] = ACT_WIDTH'(r + 1);
        for (int c = 0; c < ARRAY_COLS; c++) wgt_pat[c*WGT_WIDTH +: WGT_WIDTH] = WGT_WIDTH'(1);
        rst = 1'b1; start = 1'b0; k_len = '0; sa_any_overflow = 1'b0;
        fif.act_valid = 1'b0; fif.wgt_valid = 1'b0; fif.act_data = '0; fif.wgt_data = '0;
        tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Identity tile, no stalls
        run_tile(4, 0, 0, -1, -1);
        chk("id_latency", lat, 23);
        chk("id_row3_first", row3_first, 3);
        chk("id_dv_cycles", dv_cnt, 4);
        chk("id_enable_cycles", en_cnt, 21);
        chk("id_clear_cycles", clr_cnt, 1);
        chk("id_overflow", ovf_at_done, 0);
        chk("id_row7_total", row_tot[7], 32);
        chk("id_wgt_col0_total", wgt_tot0, 4);
        chk("id_col_sum", col_sum, 144);

        // Weight stream gap of 3 cycles after the first beat
        run_tile(4, 3, 3, -1, -1);
        chk("stall_latency", lat, 26);
        chk("stall_dv_cycles", dv_cnt, 4);
        chk("stall_enable_cycles", en_cnt, 21);
        chk("stall_row3_first", row3_first, 3);
        chk("stall_col_sum", col_sum, 144);

        // Empty tile
        run_tile(0, 0, 0, -1, -1);
        chk("k0_latency", lat, 1);
        chk("k0_clear_cycles", clr_cnt, 0);
        chk("k0_enable_cycles", en_cnt, 0);
        chk("k0_overflow", ovf_at_done, 0);

        // Overflow during DRAIN
        run_tile(4, 0, 0, 10, -1);
        chk("ovf_latency", lat, 23);
        chk("ovf_sticky_at_done", ovf_at_done, 1);

        // Start during DRAIN ignored, then back-to-back start right after DONE
        run_tile(4, 0, 0, -1, 12);
        chk("drain_start_latency", lat, 23);
        chk("drain_start_overflow", ovf_at_done, 0);
        run_tile(3, 0, 0, -1, -1);
        chk("b2b_latency", lat, 22);
        chk("b2b_dv_cycles", dv_cnt, 3);

        // Reset after two accepted beats
        k_len = K_WIDTH'(4); start = 1'b1;
        fif.act_valid = 1'b1; fif.wgt_valid = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk_all_zero("midreset");
        rst = 1'b0;
        run_tile(2, 0, 0, -1, -1);
        chk("post_reset_latency", lat, 21);
        chk("post_reset_dv_cycles", dv_cnt, 2);
        chk("post_reset_clear_cycles", clr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
